rd_ctrl: RTL
============

// Module: rd_ctrl
// PURPOSE
//  Read-side pointer controller of the dual-clock gray-pointer FIFO; counterpart of the write-side controller.
//  Synchronizes the write pointer (gray) into rd_clk and decodes it to binary.
//  Accepts an active-low read request and issues registered read enables to the storage array.
//  Maintains the binary/gray read pointer and the empty flag for the write side and local logic.
// PARAMETERS
//  ADDR_W    4  pointer width; FIFO depth = 2**ADDR_W entries
//  SYNC_DLY  2  flop stages in the wr_ptr_g and rd_req_ synchronizers (legal >= 2)
// PORTS
//  rd_clk      in   1       read-domain clock; sole clock of this block
//  rst         in   1       synchronous, active-high reset (sampled on posedge rd_clk)
//  wr_ptr_g    in   ADDR_W  write pointer, gray-coded, from write domain (asynchronous)
//  rd_req_     in   1       read request, active-low, asynchronous to rd_clk
//  rd_ptr_b    out  ADDR_W  binary read pointer = storage read address (registered)
//  rd_en       out  1       read strobe to storage array (registered)
//  rd_ptr_g    out  ADDR_W  gray encoding of rd_ptr_b, to write-domain synchronizer
//  empty       out  1       FIFO empty as seen in rd_clk domain
//  underflow   out  1       sticky read-while-empty flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at posedge): rd_ptr_b=0, rd_en=0, underflow=0, all sync stages=0 except rd_req_ stages=1;
//   internal drain_dly=0, empty_dly=1 -> empty=1, rd_ptr_g=0 during and after reset.
//  Reset mid-operation overrides everything in the same edge; no in-flight rd_en survives.
//  Sync: wr_ptr_g -> SYNC_DLY flops -> wr_ptr_s; gray->binary -> wr_ptr_bs. rd_req_ -> SYNC_DLY flops -> req_s_.
//  nxt_rd_ptr = rd_ptr_b + 1, modulo 2**ADDR_W (15 -> 0 wrap, no extra wrap bit).
//  drain = (nxt_rd_ptr == wr_ptr_bs); drain_dly <= drain; empty_dly <= empty (registered each cycle).
//  empty = (rd_ptr_b == wr_ptr_bs) && (drain_dly || empty_dly)  [combinational]
//   -> pointer equality reached by a read (or held since reset) = empty; reached by writes = full, not empty.
//  last = drain (exactly one entry left).
//  rd_en <= (req_s_==0) && !empty && !(rd_en && last); else 0.
//   -> no back-to-back strobe may consume the final entry twice; sustained request gives rd_en every cycle
//      while >=2 entries, alternate cycles at 1 entry.
//  rd_ptr_b <= rd_ptr_b + 1 on cycle after rd_en=1 (i.e. when rd_en is high at posedge); else hold.
//  Storage data for address rd_ptr_b is valid the cycle rd_en=1; pointer advances at that edge's end.
//  rd_ptr_g = rd_ptr_b ^ (rd_ptr_b >> 1), combinational from registered rd_ptr_b (single-bit change per step).
//  Latency: rd_req_ fall -> rd_en=1 after SYNC_DLY+1 edges if not empty; write commit -> empty deassert
//   after SYNC_DLY edges of rd_clk (+ write-side gray latency).
//  Simultaneous write arrival and read: empty evaluated on current wr_ptr_bs only; conservative by design.
//  rd_req_ deasserted: rd_en drops on the next edge after req_s_ returns to 1.
// CONFIGURATION
//  RD_CTRL_UNDERFLOW_EN defined: underflow <= 1 when req_s_==0 && empty at posedge; sticky until rst.
//  RD_CTRL_UNDERFLOW_EN undefined: underflow tied to 0; no extra flops; port still present.
//  Pointer/enable behaviour identical in both builds.
// TESTING
//  1 Reset: rst=1 3 cycles, wr_ptr_g=0, rd_req_=0 -> empty=1, rd_en=0, rd_ptr_b=0, rd_ptr_g=0 throughout.
//  2 Single entry: wr_ptr_g 0->1, rd_req_=0 -> empty=0 after 2 edges; exactly one rd_en pulse;
//    rd_ptr_b=1, rd_ptr_g=4'b0001, empty=1 afterward; no second rd_en.
//  3 Burst: wr_ptr_g stepped to gray(5), rd_req_=0 held -> rd_en pulses total 5, rd_ptr_b ends 5,
//    rd_ptr_g=4'b0111, empty=1, rd_ptr_g changes one bit per step.
//  4 Wrap: preload rd_ptr_b=14 via reads, write to gray(2) (wrapped) -> reads at 14,15,0,1; rd_ptr_b=2, empty=1.
//  5 Full not empty: writer fills 16 entries from rd_ptr_b=0 (wr_ptr_g returns to 0 via 1..15) -> empty=0,
//    16 reads then empty=1.
//  6 Underflow (macro on): empty=1, rd_req_=0 for 4 cycles -> underflow=1 sticky, rd_en=0; macro off -> underflow=0;
//    rst=1 mid-burst -> all outputs to reset values next edge.

Source files
------------

// File: rtl/rd_ctrl.sv
// ---------------------------------------------------------------------------
// rd_ctrl
//   Read-side pointer controller for a dual-clock FIFO with gray-coded
//   pointers. The write pointer (gray) is brought into rd_clk through a
//   SYNC_DLY-deep flop chain and decoded to binary. The active-low read
//   request is synchronized the same way. A registered read strobe is issued
//   to the storage array while unread entries exist, and the binary/gray read
//   pointer is advanced one edge after each strobe.
//
// Parameters
//   ADDR_W    pointer width, FIFO depth = 2**ADDR_W
//   SYNC_DLY  synchronizer depth for wr_ptr_g and rd_req_ (>= 2)
//
// Ports
//   rd_clk     in   read-domain clock
//   rst        in   synchronous active-high reset
//   wr_ptr_g   in   gray write pointer from the write domain (asynchronous)
//   rd_req_    in   active-low read request (asynchronous)
//   rd_ptr_b   out  binary read pointer / storage read address (registered)
//   rd_en      out  read strobe to the storage array (registered)
//   rd_ptr_g   out  gray form of rd_ptr_b for the write-domain synchronizer
//   empty      out  FIFO empty in the rd_clk domain
//   underflow  out  sticky read-while-empty flag
//
// Build option
//   RD_CTRL_UNDERFLOW_EN  when defined, underflow latches on any cycle where
//                         the synchronized request is active while empty;
//                         otherwise underflow is tied low and has no flop.
// ---------------------------------------------------------------------------
module rd_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int SYNC_DLY = 2
) (
    input  logic              rd_clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wr_ptr_g,
    input  logic              rd_req_,
    output logic [ADDR_W-1:0] rd_ptr_b,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_ptr_g,
    output logic              empty,
    output logic              underflow
);

    logic [ADDR_W-1:0]   wsync_q [SYNC_DLY];
    logic [ADDR_W-1:0]   wsync_d [SYNC_DLY];
    logic [SYNC_DLY-1:0] rsync_q;
    logic [SYNC_DLY-1:0] rsync_d;

    logic [ADDR_W-1:0]   rd_ptr_b_q;
    logic [ADDR_W-1:0]   rd_ptr_b_d;
    logic                rd_en_q;
    logic                rd_en_d;
    logic                drain_dly_q;
    logic                drain_dly_d;
    logic                empty_dly_q;
    logic                empty_dly_d;

    logic [ADDR_W-1:0]   wr_ptr_s;
    logic [ADDR_W-1:0]   wr_ptr_bs;
    logic                req_s_;
    logic [ADDR_W-1:0]   nxt_rd_ptr;
    logic                drain;
    logic                empty_c;

    assign wr_ptr_s = wsync_q[SYNC_DLY-1];
    assign req_s_   = rsync_q[SYNC_DLY-1];

    always_comb begin
        wsync_d[0] = wr_ptr_g;
        for (int i = 1; i < SYNC_DLY; i++) begin
            wsync_d[i] = wsync_q[i-1];
        end
        rsync_d = {rsync_q[SYNC_DLY-2:0], rd_req_};
    end

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        wr_ptr_bs = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            wr_ptr_bs[i] = ^(wr_ptr_s >> i);
        end
    end

    // Pointer equality alone cannot tell empty from full. Equality reached by
    // a read (drain_dly) or held since an already-empty cycle (empty_dly) is
    // empty; equality reached by writes is full.
    always_comb begin
        nxt_rd_ptr  = rd_ptr_b_q + ADDR_W'(1);
        drain       = (nxt_rd_ptr == wr_ptr_bs);
        empty_c     = (rd_ptr_b_q == wr_ptr_bs) && (drain_dly_q || empty_dly_q);
        drain_dly_d = drain;
        empty_dly_d = empty_c;

        // A strobe already in flight has claimed the last entry, so the
        // following cycle must not strobe it again.
        rd_en_d = !req_s_ && !empty_c && !(rd_en_q && drain);

        rd_ptr_b_d = rd_ptr_b_q;
        if (rd_en_q) begin
            rd_ptr_b_d = nxt_rd_ptr;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_DLY; i++) begin
                wsync_q[i] <= '0;
            end
            rsync_q     <= '1;
            rd_ptr_b_q  <= '0;
            rd_en_q     <= 1'b0;
            drain_dly_q <= 1'b0;
            empty_dly_q <= 1'b1;
        end else begin
            wsync_q     <= wsync_d;
            rsync_q     <= rsync_d;
            rd_ptr_b_q  <= rd_ptr_b_d;
            rd_en_q     <= rd_en_d;
            drain_dly_q <= drain_dly_d;
            empty_dly_q <= empty_dly_d;
        end
    end

`ifdef RD_CTRL_UNDERFLOW_EN
    logic underflow_q;
    logic underflow_d;

    always_comb begin
        underflow_d = underflow_q || (!req_s_ && empty_c);
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign underflow = underflow_q;
`else
    assign underflow = 1'b0;
`endif

    assign rd_ptr_b = rd_ptr_b_q;
    assign rd_en    = rd_en_q;
    assign rd_ptr_g = rd_ptr_b_q ^ (rd_ptr_b_q >> 1);
    assign empty    = empty_c;

endmodule
